// File: rtl/init_seq_pkg.sv
// Shared types and helpers for the power-up init sequencer.
package init_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RELEASE,
    S_WAIT_DONE,
    S_SETTLE,
    S_RETRY_HOLD,
    S_GATE,
    S_RUN,
    S_FAIL
  } state_t;

  // Upper bound on channel count; masks are zero-extended to this width.
  localparam int MAX_CH = 32;

  // Lowest index >= from whose mask bit is clear. Returns MAX_CH when none exist.
  // Bits beyond a real channel count are zero, so callers compare against NUM_CH.
  function automatic int first_ch(input logic [MAX_CH-1:0] mask, input int from);
    int idx;
    idx = MAX_CH;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (i >= from && !mask[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/init_seq_ctrl_if.sv
// Sequencer-facing bundle: start/done handshake, channel resets, status and shared-bus pins.
interface init_seq_ctrl_if #(
  parameter int NUM_CH = 3,
  parameter int AW     = 2
);
  logic              i_start;
  logic [NUM_CH-1:0] i_ch_done;
  logic [NUM_CH-1:0] ch_scl_oe;
  logic [NUM_CH-1:0] ch_sda_oe;
  logic [NUM_CH-1:0] o_ch_rst_n;
  logic [NUM_CH-1:0] o_bus_grant;
  logic [AW-1:0]     o_active_ch;
  logic [NUM_CH-1:0] o_progress;
  logic              o_run;
  logic              o_fail;
  logic [NUM_CH-1:0] o_fail_mask;
  logic              bus_scl_oe;
  logic              bus_sda_oe;

  modport master (
    input  i_start, i_ch_done, ch_scl_oe, ch_sda_oe,
    output o_ch_rst_n, o_bus_grant, o_active_ch, o_progress,
           o_run, o_fail, o_fail_mask, bus_scl_oe, bus_sda_oe
  );

  modport slave (
    output i_start, i_ch_done, ch_scl_oe, ch_sda_oe,
    input  o_ch_rst_n, o_bus_grant, o_active_ch, o_progress,
           o_run, o_fail, o_fail_mask, bus_scl_oe, bus_sda_oe
  );
endinterface

// File: rtl/init_seq_timer.sv
// Loadable saturating down-counter; expire is high while the count sits at zero.
module init_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == '0);
endmodule

// File: rtl/init_seq_ctrl.sv
// Power-up sequencer: releases channel resets in order, arbitrates the shared
// management bus, retries on timeout and raises run once every channel is done.
module init_seq_ctrl
  import init_seq_pkg::*;
#(
  parameter int                NUM_CH      = 3,
  parameter logic [NUM_CH-1:0] PRE_MASK    = 3'b100,
  parameter logic [NUM_CH-1:0] BUS_MASK    = 3'b011,
  parameter int                TIMEOUT_CYC = 27_000_000,
  parameter int                SETTLE_CYC  = 270,
  parameter int                MAX_RETRY   = 2,
  parameter bit                AUTO_REINIT = 1'b0
) (
  input logic             clk,
  input logic             rst,
  init_seq_ctrl_if.master bus
);
  localparam int AW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = $clog2(max2(TIMEOUT_CYC, SETTLE_CYC) + 1);
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] SET_LOAD = CW'(SETTLE_CYC - 1);
  localparam int FIRST_CH = first_ch(MAX_CH'(PRE_MASK), 0);

  state_t            state;
  logic [AW-1:0]     active;
  logic [RW-1:0]     retries;
  logic [NUM_CH-1:0] ch_rst_n, grant, progress, fail_mask;
  logic              run, fail;

  logic              tmr_load, tmr_expire;
  logic [CW-1:0]     tmr_val;
  int                next_idx, drop_idx;
  logic [NUM_CH-1:0] drop, reinit_mask;
  logic              reinit;

  assign drop   = ~bus.i_ch_done & ~PRE_MASK;
  assign reinit = AUTO_REINIT && (state == S_RUN) && (|drop);

  // NOTE: every signal written in an always_comb gets a default first, so no path leaves it holding a stale value (which would infer a latch).
  always_comb begin
    next_idx    = first_ch(MAX_CH'(PRE_MASK), int'(active) + 1);
    drop_idx    = 0;
    reinit_mask = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (drop[i]) drop_idx = i;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      reinit_mask[i] = !PRE_MASK[i] && (i >= drop_idx);
    end
  end

  // One timer serves every timed state; each entry edge reloads it.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = TMO_LOAD;
    case (state)
      S_IDLE:      tmr_load = bus.i_start;
      S_RELEASE:   tmr_load = 1'b1;
      S_WAIT_DONE: if (bus.i_ch_done[active] || tmr_expire) begin
                     tmr_load = 1'b1;
                     tmr_val  = SET_LOAD;
                   end
      S_SETTLE:    tmr_load = tmr_expire;
      S_RUN:       if (reinit) begin
                     tmr_load = 1'b1;
                     tmr_val  = SET_LOAD;
                   end
      default:     tmr_load = 1'b0;
    endcase
  end

  init_seq_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values, matching the hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      active    <= '0;
      retries   <= '0;
      ch_rst_n  <= '0;
      grant     <= '0;
      progress  <= '0;
      fail_mask <= '0;
      run       <= 1'b0;
      fail      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (bus.i_start) begin
          ch_rst_n <= PRE_MASK;
          retries  <= '0;
          if (FIRST_CH < NUM_CH) begin
            active <= AW'(FIRST_CH);
            state  <= S_RELEASE;
          end else begin
            state  <= S_GATE;
          end
        end
        S_RELEASE: begin
          ch_rst_n[active] <= 1'b1;
          grant            <= BUS_MASK[active] ? (NUM_CH'(1) << active) : '0;
          state            <= S_WAIT_DONE;
        end
        // Done is tested first so a done landing on the timeout cycle still counts.
        S_WAIT_DONE: if (bus.i_ch_done[active]) begin
          progress[active] <= 1'b1;
          grant            <= '0;
          state            <= S_SETTLE;
        end else if (tmr_expire) begin
          grant <= '0;
          if (int'(retries) < MAX_RETRY) begin
            retries          <= retries + 1'b1;
            ch_rst_n[active] <= 1'b0;
            state            <= S_RETRY_HOLD;
          end else begin
            fail_mask[active] <= 1'b1;
            fail              <= 1'b1;
            state             <= S_FAIL;
          end
        end
        S_SETTLE: if (tmr_expire) begin
          retries <= '0;
          if (next_idx < NUM_CH) begin
            active <= AW'(next_idx);
            state  <= S_RELEASE;
          end else begin
            state  <= S_GATE;
          end
        end
        // Reset comes off as the hold ends, so it stays low exactly SETTLE_CYC cycles.
        S_RETRY_HOLD: if (tmr_expire) begin
          ch_rst_n[active] <= 1'b1;
          state            <= S_RELEASE;
        end
        S_GATE: begin
          progress <= progress | (bus.i_ch_done & PRE_MASK);
          if (&bus.i_ch_done) begin
            run   <= 1'b1;
            state <= S_RUN;
          end else if (tmr_expire) begin
            fail_mask <= fail_mask | (PRE_MASK & ~bus.i_ch_done);
            fail      <= 1'b1;
            state     <= S_FAIL;
          end
        end
        S_RUN: if (reinit) begin
          run      <= 1'b0;
          ch_rst_n <= ch_rst_n & ~reinit_mask;
          progress <= progress & ~reinit_mask;
          active   <= AW'(drop_idx);
          retries  <= '0;
          state    <= S_RETRY_HOLD;
        end
        S_FAIL:  state <= S_FAIL;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_ch_rst_n  = ch_rst_n;
  assign bus.o_bus_grant = grant;
  assign bus.o_active_ch = active;
  assign bus.o_progress  = progress;
  assign bus.o_run       = run;
  assign bus.o_fail      = fail;
  assign bus.o_fail_mask = fail_mask;

  // Open-drain pull-down enables reach the shared pins only from the granted channel.
  assign bus.bus_scl_oe = |(bus.ch_scl_oe & grant);
  assign bus.bus_sda_oe = |(bus.ch_sda_oe & grant);
endmodule

// File: tb/tb_init_seq_ctrl.sv
// Directed bench for init_seq_ctrl: two instances (AUTO_REINIT 0 and 1) share stimulus.
module tb_init_seq_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] ch_done = '0;
  logic [2:0] scl_oe = '0;
  logic [2:0] sda_oe = '0;
  int         checks = 0;
  int         errors = 0;
  logic [15:0] exp;

  always #5 clk = ~clk;

  init_seq_ctrl_if #(.NUM_CH(3), .AW(2)) bus0 ();
  init_seq_ctrl_if #(.NUM_CH(3), .AW(2)) bus1 ();

  assign bus0.i_start = start;   assign bus1.i_start = start;
  assign bus0.i_ch_done = ch_done; assign bus1.i_ch_done = ch_done;
  assign bus0.ch_scl_oe = scl_oe;  assign bus1.ch_scl_oe = scl_oe;
  assign bus0.ch_sda_oe = sda_oe;  assign bus1.ch_sda_oe = sda_oe;

  init_seq_ctrl #(.NUM_CH(3), .PRE_MASK(3'b100), .BUS_MASK(3'b011), .TIMEOUT_CYC(20),
                  .SETTLE_CYC(4), .MAX_RETRY(2), .AUTO_REINIT(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  init_seq_ctrl #(.NUM_CH(3), .PRE_MASK(3'b100), .BUS_MASK(3'b011), .TIMEOUT_CYC(20),
                  .SETTLE_CYC(4), .MAX_RETRY(2), .AUTO_REINIT(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.master));

  // {rst_n, grant, active, progress, run, fail, fail_mask}
  function automatic logic [15:0] mk(input logic [2:0] rn, input logic [2:0] g, input logic [1:0] a,
                                     input logic [2:0] p, input logic r, input logic f, input logic [2:0] fm);
    return {rn, g, a, p, r, f, fm};
  endfunction
  function automatic logic [15:0] snap0();
    return {bus0.o_ch_rst_n, bus0.o_bus_grant, bus0.o_active_ch, bus0.o_progress,
            bus0.o_run, bus0.o_fail, bus0.o_fail_mask};
  endfunction
  function automatic logic [15:0] snap1();
    return {bus1.o_ch_rst_n, bus1.o_bus_grant, bus1.o_active_ch, bus1.o_progress,
            bus1.o_run, bus1.o_fail, bus1.o_fail_mask};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; ch_done = '0; scl_oe = '0; sda_oe = '0;
    step(3);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; ch_done = 3'b111;
    step(3);
    checks++; if (snap0() !== 16'h0) begin errors++; $display("FAIL reset_dut0 got=%b want=%b", snap0(), 16'h0); end
    checks++; if (snap1() !== 16'h0) begin errors++; $display("FAIL reset_dut1 got=%b want=%b", snap1(), 16'h0); end
    apply_reset();
  endtask

  task automatic test_nominal();
    apply_reset();
    ch_done = 3'b100; scl_oe = 3'b110; sda_oe = 3'b001; start = 1'b1;
    step(1); start = 1'b0;
    exp = mk(3'b100, 3'b000, 2'd0, 3'b000, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL nom_release0 got=%b want=%b", snap0(), exp); end
    checks++; if ({bus0.bus_scl_oe, bus0.bus_sda_oe} !== 2'b00) begin errors++; $display("FAIL nom_pins_idle got=%b want=00", {bus0.bus_scl_oe, bus0.bus_sda_oe}); end
    step(1);
    exp = mk(3'b101, 3'b001, 2'd0, 3'b000, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL nom_wait0 got=%b want=%b", snap0(), exp); end
    checks++; if ({bus0.bus_scl_oe, bus0.bus_sda_oe} !== 2'b01) begin errors++; $display("FAIL nom_pins_ch0 got=%b want=01", {bus0.bus_scl_oe, bus0.bus_sda_oe}); end
    step(5);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL nom_wait0_late got=%b want=%b", snap0(), exp); end
    ch_done[0] = 1'b1;
    step(1);
    exp = mk(3'b101, 3'b000, 2'd0, 3'b001, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL nom_done0 got=%b want=%b", snap0(), exp); end
    step(3);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL nom_settle_end got=%b want=%b", snap0(), exp); end
    step(1);
    exp = mk(3'b101, 3'b000, 2'd1, 3'b001, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL nom_release1 got=%b want=%b", snap0(), exp); end
    step(1);
    exp = mk(3'b111, 3'b010, 2'd1, 3'b001, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL nom_wait1 got=%b want=%b", snap0(), exp); end
    checks++; if ({bus0.bus_scl_oe, bus0.bus_sda_oe} !== 2'b10) begin errors++; $display("FAIL nom_pins_ch1 got=%b want=10", {bus0.bus_scl_oe, bus0.bus_sda_oe}); end
    step(3); ch_done[1] = 1'b1;
    step(1);
    exp = mk(3'b111, 3'b000, 2'd1, 3'b011, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL nom_done1 got=%b want=%b", snap0(), exp); end
    step(4);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL nom_gate got=%b want=%b", snap0(), exp); end
    step(1);
    exp = mk(3'b111, 3'b000, 2'd1, 3'b111, 1, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL nom_run got=%b want=%b", snap0(), exp); end
  endtask

  task automatic test_timeout_retry();
    int low;
    apply_reset();
    ch_done = 3'b100; start = 1'b1;
    step(1); start = 1'b0;
    step(20);
    exp = mk(3'b101, 3'b001, 2'd0, 3'b000, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL tmo_last_wait got=%b want=%b", snap0(), exp); end
    low = 0;
    for (int i = 0; i < 6; i++) begin
      step(1);
      if (bus0.o_ch_rst_n[0] === 1'b0) low++;
      if (i == 0) begin
        exp = mk(3'b100, 3'b000, 2'd0, 3'b000, 0, 0, 3'b000);
        checks++; if (snap0() !== exp) begin errors++; $display("FAIL tmo_hold got=%b want=%b", snap0(), exp); end
      end
      if (i == 4) begin
        exp = mk(3'b101, 3'b000, 2'd0, 3'b000, 0, 0, 3'b000);
        checks++; if (snap0() !== exp) begin errors++; $display("FAIL tmo_rerelease got=%b want=%b", snap0(), exp); end
      end
    end
    checks++; if (low != 4) begin errors++; $display("FAIL tmo_rst_low_cycles got=%0d want=4", low); end
    exp = mk(3'b101, 3'b001, 2'd0, 3'b000, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL tmo_wait_retry got=%b want=%b", snap0(), exp); end
    ch_done[0] = 1'b1;
    step(1);
    exp = mk(3'b101, 3'b000, 2'd0, 3'b001, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL tmo_done got=%b want=%b", snap0(), exp); end
    step(5);
    exp = mk(3'b111, 3'b010, 2'd1, 3'b001, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL tmo_continue got=%b want=%b", snap0(), exp); end
  endtask

  task automatic test_retry_exhaust();
    apply_reset();
    ch_done = 3'b100; start = 1'b1;
    step(1); start = 1'b0;
    step(6); ch_done[0] = 1'b1;
    step(6);
    exp = mk(3'b111, 3'b010, 2'd1, 3'b001, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL exh_wait1 got=%b want=%b", snap0(), exp); end
    step(20);
    exp = mk(3'b101, 3'b000, 2'd1, 3'b001, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL exh_retry1 got=%b want=%b", snap0(), exp); end
    step(49);
    exp = mk(3'b111, 3'b010, 2'd1, 3'b001, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL exh_last_wait got=%b want=%b", snap0(), exp); end
    step(1);
    exp = mk(3'b111, 3'b000, 2'd1, 3'b001, 0, 1, 3'b010);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL exh_fail got=%b want=%b", snap0(), exp); end
    ch_done = 3'b111; start = 1'b1;
    step(10); start = 1'b0;
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL exh_terminal got=%b want=%b", snap0(), exp); end
  endtask

  task automatic test_race();
    apply_reset();
    ch_done = 3'b100; start = 1'b1;
    step(1); start = 1'b0;
    step(20);
    ch_done[0] = 1'b1;
    step(1);
    exp = mk(3'b101, 3'b000, 2'd0, 3'b001, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL race_done_wins got=%b want=%b", snap0(), exp); end
    step(4);
    exp = mk(3'b101, 3'b000, 2'd1, 3'b001, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL race_next_ch got=%b want=%b", snap0(), exp); end
  endtask

  task automatic test_auto_reinit();
    apply_reset();
    ch_done = 3'b100; start = 1'b1;
    step(1); start = 1'b0;
    step(6); ch_done[0] = 1'b1;
    step(9); ch_done[1] = 1'b1;
    step(6);
    exp = mk(3'b111, 3'b000, 2'd1, 3'b111, 1, 0, 3'b000);
    checks++; if (snap1() !== exp) begin errors++; $display("FAIL ari_run got=%b want=%b", snap1(), exp); end
    step(2); ch_done = 3'b110;
    step(1);
    exp = mk(3'b100, 3'b000, 2'd0, 3'b100, 0, 0, 3'b000);
    checks++; if (snap1() !== exp) begin errors++; $display("FAIL ari_drop got=%b want=%b", snap1(), exp); end
    exp = mk(3'b111, 3'b000, 2'd1, 3'b111, 1, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL ari_off_ignores got=%b want=%b", snap0(), exp); end
    step(3);
    exp = mk(3'b100, 3'b000, 2'd0, 3'b100, 0, 0, 3'b000);
    checks++; if (snap1() !== exp) begin errors++; $display("FAIL ari_hold got=%b want=%b", snap1(), exp); end
    step(1);
    exp = mk(3'b101, 3'b000, 2'd0, 3'b100, 0, 0, 3'b000);
    checks++; if (snap1() !== exp) begin errors++; $display("FAIL ari_release0 got=%b want=%b", snap1(), exp); end
    step(1);
    exp = mk(3'b101, 3'b001, 2'd0, 3'b100, 0, 0, 3'b000);
    checks++; if (snap1() !== exp) begin errors++; $display("FAIL ari_wait0 got=%b want=%b", snap1(), exp); end
    ch_done[0] = 1'b1;
    step(1);
    exp = mk(3'b101, 3'b000, 2'd0, 3'b101, 0, 0, 3'b000);
    checks++; if (snap1() !== exp) begin errors++; $display("FAIL ari_done0 got=%b want=%b", snap1(), exp); end
    step(5);
    exp = mk(3'b111, 3'b010, 2'd1, 3'b101, 0, 0, 3'b000);
    checks++; if (snap1() !== exp) begin errors++; $display("FAIL ari_wait1 got=%b want=%b", snap1(), exp); end
    step(6);
    exp = mk(3'b111, 3'b000, 2'd1, 3'b111, 1, 0, 3'b000);
    checks++; if (snap1() !== exp) begin errors++; $display("FAIL ari_rerun got=%b want=%b", snap1(), exp); end
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL ari_off_still_run got=%b want=%b", snap0(), exp); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ch_done = 3'b100; start = 1'b1;
    step(1); start = 1'b0;
    step(6); ch_done[0] = 1'b1;
    step(6);
    exp = mk(3'b111, 3'b010, 2'd1, 3'b001, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL mid_pre got=%b want=%b", snap0(), exp); end
    step(2); rst = 1'b1;
    step(1);
    checks++; if (snap0() !== 16'h0) begin errors++; $display("FAIL mid_reset got=%b want=%b", snap0(), 16'h0); end
    rst = 1'b0;
    step(2);
    checks++; if (snap0() !== 16'h0) begin errors++; $display("FAIL mid_idle got=%b want=%b", snap0(), 16'h0); end
    start = 1'b1;
    step(1); start = 1'b0;
    exp = mk(3'b100, 3'b000, 2'd0, 3'b000, 0, 0, 3'b000);
    checks++; if (snap0() !== exp) begin errors++; $display("FAIL mid_restart got=%b want=%b", snap0(), exp); end
  endtask

  initial begin
    step(1);
    test_reset();
    test_nominal();
    test_timeout_retry();
    test_retry_exhaust();
    test_race();
    test_auto_reinit();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/init_seq_ctrl.md
Name: init_seq_ctrl

Overview:
- Parametrised power-up sequencer: releases per-channel resets (MAC, camera, DDR3, ...) in a fixed order and waits for each channel's done flag.
- Arbitrates ownership of the shared SCL/MDC–SDA/MDIO pins among channels that need them during init.
- Supports timeout, bounded retry, pre-released background channels, and a final run-enable for downstream logic (MJPEG path, DDR3 master).
- Sits in the top level between board reset logic and the subsystem tops.

Parameters:
- NUM_CH, 3, number of sequenced channels; order is index 0 to NUM_CH-1.
- PRE_MASK, 3'b100, channels released at start and only checked at the final gate (DDR3 calibration style).
- BUS_MASK, 3'b011, channels that own the shared management bus while they are the active channel.
- TIMEOUT_CYC, 27_000_000, maximum cycles in WAIT_DONE per attempt (1 s at 27 MHz).
- SETTLE_CYC, 270, gap cycles after a channel completes, before the next reset is released.
- MAX_RETRY, 2, re-attempts per channel after a timeout.
- AUTO_REINIT, 0, when 1, loss of a done flag in RUN restarts the sequence from the lowest failed channel.

Ports:
- clk  in  1  system clock (27 MHz).
- rst  in  1  synchronous, active-high reset.
- i_start  in  1  level; the sequence begins on the first cycle it is high in IDLE.
- i_ch_done  in  NUM_CH  per-channel init-done, level, already synchronous to clk.
- o_ch_rst_n  out  NUM_CH  per-channel active-low reset.
- o_bus_grant  out  NUM_CH  one-hot or all-zero shared-bus ownership.
- o_active_ch  out  $clog2(NUM_CH)  channel currently being initialised.
- o_progress  out  NUM_CH  bitmap of completed channels (LED use).
- o_run  out  1  high when all channels are done; gates downstream resets.
- o_fail  out  1  sticky fail flag.
- o_fail_mask  out  NUM_CH  sticky; channels that exhausted their retries.

Behaviour:
- Decided: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values:
  - o_ch_rst_n = 0.
  - o_bus_grant = 0.
  - o_active_ch = 0.
  - o_progress = 0.
  - o_run = 0.
  - o_fail = 0.
  - o_fail_mask = 0.
  - Internal counters = 0; state = IDLE.
- Reset mid-operation: all channel resets are re-asserted on the next edge, with no ordering.
- States: IDLE, RELEASE, WAIT_DONE, SETTLE, RETRY_HOLD, GATE, RUN, FAIL.
- IDLE:
  - On i_start, set o_ch_rst_n[k] = 1 for all PRE_MASK channels in the same transition.
  - Set o_active_ch to the first non-PRE channel, then go to RELEASE.
  - If every channel is PRE, go directly to GATE.
- RELEASE (1 cycle):
  - Deassert o_ch_rst_n[active].
  - Grant the bus if BUS_MASK[active] = 1.
  - Clear the timeout counter; go to WAIT_DONE.
- WAIT_DONE, done arrives:
  - A done seen in cycle t sets o_progress[active] at t+1.
  - Drop the grant at t+1; go to SETTLE.
- WAIT_DONE, timeout:
  - The counter reaching TIMEOUT_CYC-1 without done causes a timeout.
  - If retries < MAX_RETRY: increment retries, reassert o_ch_rst_n[active], drop the grant, go to RETRY_HOLD.
  - Otherwise: set o_fail_mask[active] and o_fail, go to FAIL.
- Done in the same cycle as timeout: done wins.
- RETRY_HOLD: hold reset for SETTLE_CYC cycles, then go to RELEASE.
- SETTLE:
  - Count SETTLE_CYC cycles.
  - Then advance to the next non-PRE channel and clear retries; go to RELEASE.
  - If no non-PRE channel remains, go to GATE.
- GATE:
  - Wait until i_ch_done is all ones; PRE channels set their o_progress bits when seen done.
  - The timeout applies as one shared window with no retry; expiry sets o_fail_mask for the PRE channels still not done, then goes to FAIL.
  - When all done, set o_run = 1 on the next cycle and go to RUN.
- RUN:
  - o_run held at 1.
  - AUTO_REINIT = 0: i_ch_done is ignored.
  - AUTO_REINIT = 1: on any non-PRE done dropping, take the lowest such channel c. Clear o_run, reassert resets for channel c and all higher non-PRE channels, clear their progress bits, set active = c, go to RETRY_HOLD.
- FAIL:
  - Terminal until rst.
  - Channels already released stay released; o_run = 0.
- o_bus_grant invariants:
  - Never more than one bit set.
  - Always zero outside WAIT_DONE.
- Counter width: $clog2(max(TIMEOUT_CYC, SETTLE_CYC)+1). Counters saturate rather than wrap.

Decomposition:
- Package init_seq_pkg:
  - State enum.
  - Function first_ch(mask, from) returning the next index not in PRE_MASK.
- Sub-module init_seq_timer: loadable down-counter with an expire pulse, shared by the SETTLE, RETRY_HOLD, WAIT_DONE and GATE states.
- Bus pin muxing stays in the top, driven from o_bus_grant.

Test Plan:
Bench parameters: NUM_CH=3, PRE_MASK=100, BUS_MASK=011, TIMEOUT_CYC=20, SETTLE_CYC=4, MAX_RETRY=2.
- Nominal sequence.
  - Stimulus: i_start; done[0] 5 cycles after its release, done[1] 3 cycles after, done[2] already high.
  - Required: o_ch_rst_n = 100, then 101, then 111; grants 001 then 010 with no overlap; o_run rises after the final GATE.
- Single timeout then success.
  - Stimulus: ch0 done withheld for 20 cycles, then supplied.
  - Required: rst_n[0] low for 4 cycles, one retry, progress = 001, sequence continues.
- Retries exhausted.
  - Stimulus: ch1 never done.
  - Required: after 3×20 wait cycles, o_fail = 1 and o_fail_mask = 010; grant = 0; rst_n[0] stays 1.
- Same-cycle race.
  - Stimulus: done[0] rises on the timeout cycle.
  - Required: counted as success, no retry.
- AUTO_REINIT = 1.
  - Stimulus: done[0] drops in RUN.
  - Required: o_run falls; rst_n = 100; progress = 100; full re-sequence from ch0.
- Reset mid-WAIT_DONE.
  - Stimulus: rst asserted while active = 1 and grant = 010.
  - Required: next edge has all outputs at reset values; state IDLE.
